cdc_c2g_tx: RTL and testbench
=============================

# cdc_c2g_tx

Counter-clock-domain transmitter for the counter→global (c2g) crossing. Timestamps discriminator events, forms the inter-event time difference and a running event number, then presents them on `c_detect_c2g` / `c_diff_c2g` / `c_diff_count_c2g`. The handshake is shaped for a 2-flop synchroniser plus rising-edge detector on the g_clk side: data is held stable around a long detect level. Sits between the PMT pulse discriminator and the g_clk RAM-write path.

## Interface
- `DATASIZE`, 16: width of the time difference, in c_clk cycles.
- `COUNTSIZE`, 32: width of the event number and of the drop counter.
- `SETUP_CYC`, 2: c_clk cycles that data is stable before detect rises; must be ≥1.
- `HOLD_CYC`, 8: c_clk cycles detect stays high, and then stays low, per transfer. Must be ≥1 and must cover at least 3 g_clk periods.
- `c_clk` in 1: counter-domain clock; the only clock.
- `c_rst` in 1: reset, asynchronous, active-high.
- `c_enable` in 1: enables the timer and event acceptance.
- `c_event` in 1: single-cycle event pulse, synchronous to c_clk.
- `c_detect_c2g` out 1: registered transfer-strobe level.
- `c_diff_c2g` out DATASIZE: registered time difference.
- `c_diff_count_c2g` out COUNTSIZE: registered event number.
- `c_busy` out 1: high when the FSM is not IDLE.
- `c_drop` out 1: one-cycle pulse when an event is discarded.
- `c_drops` out COUNTSIZE: number of discarded events; wraps.

## Operation
- Reset value of every output and internal register is 0. After reset: FSM in IDLE, pending slot empty.
- **Timer** (DATASIZE bits)
  - Increments once per edge while `c_enable`=1, saturating at 2^DATASIZE−1.
  - Frozen while `c_enable`=0.
- **Accepted event** (`c_event`=1 and `c_enable`=1 at an edge):
  - Captured diff = current timer value.
  - Timer loads 1 at that edge. Two events k edges apart therefore give diff=k, saturated.
  - Event counter increments, wrapping mod 2^COUNTSIZE. Captured count = the new value, so the first event is 1.
  - Events with `c_enable`=0 are ignored entirely.
- **Event routing**
  - FSM in IDLE: the event loads directly into a transfer.
  - FSM not IDLE, pending slot empty: the captured {diff, count} goes to the pending slot.
  - FSM not IDLE, pending slot full: the event is dropped. `c_drop` pulses and `c_drops` increments. The event number is still consumed.
- **FSM states**
  - IDLE: detect 0. If the pending slot is full, load the pending entry. Otherwise, if an event is accepted, load that event.
  - SETUP: lasts SETUP_CYC cycles, detect 0.
  - ASSERT: lasts HOLD_CYC cycles, detect 1.
  - RELEASE: lasts HOLD_CYC cycles, detect 0, then return to IDLE.
- **Load**
  - The data outputs register the entry and the FSM enters SETUP.
  - The data outputs change only on a load and hold their value indefinitely otherwise.
- **Simultaneous events**
  - In IDLE with the pending slot full and a new event accepted on the same edge: the pending entry loads and the new event enters the now-free pending slot. No drop.
- **Reset mid-transfer**: detect and all outputs go to 0 asynchronously; the pending entry is lost.

## Timing
- Event sampled at edge E, FSM in IDLE:
  - Data outputs and `c_busy`=1 are valid after edge E.
  - `c_detect_c2g` rises at edge E+SETUP_CYC and falls at edge E+SETUP_CYC+HOLD_CYC.
  - FSM returns to IDLE at edge E+P, where P = SETUP_CYC+2·HOLD_CYC (defaults: rise E+2, fall E+10, IDLE E+18).
- A pending entry loads at edge E+P+1. Back-to-back load spacing is P+1 = 19 cycles by default.
- Data outputs are stable from SETUP_CYC cycles before detect rises until the next load, which comes at least HOLD_CYC cycles after detect falls. The g_clk receiver therefore samples stable data one cycle after its synchronised detect.
- `c_drop` is high during the cycle after the edge at which the drop occurred, and `c_drops` updates at that same edge.

## Test plan
- Assert `c_rst` for 5 cycles mid-run, then release → all outputs 0, `c_busy`=0, `c_drops`=0.
- Events at edges 100 and 137, enable high → second transfer: diff=37, count=2; detect high exactly 8 cycles, edges 139–147; data unchanged from edge 137 until the next load.
- Two events 70000 edges apart, DATASIZE=16 → diff=65535 (saturated).
- Three events on consecutive edges 200–202 from IDLE → transfers count=1 (load 200) and count=2 (load 219, diff=1); third dropped: `c_drop` one pulse, `c_drops`=1. Next event carries count=4.
- `c_enable`=0 for 50 cycles with 5 pulses on `c_event` → no transfer, timer frozen, event counter unchanged.
- `c_rst` asserted during ASSERT with the pending slot full → detect 0 immediately. After release no transfer occurs, and the next event gives count=1.

Source files
------------

// File: rtl/cdc_c2g_tx.sv
// cdc_c2g_tx: counter-domain side of the c2g crossing.
// Each accepted discriminator event is timestamped against the previous one
// and given a running event number. The {diff, count} pair is then presented
// with a slow detect level for a 2-flop synchroniser and edge detector in g_clk.
// One extra event can wait in a pending slot. Any further event that arrives
// while a transfer is in flight is counted as a drop.
module cdc_c2g_tx #(
    parameter int DATASIZE  = 16,
    parameter int COUNTSIZE = 32,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 8
) (
    input  logic                 c_clk,
    input  logic                 c_rst,
    input  logic                 c_enable,
    input  logic                 c_event,
    output logic                 c_detect_c2g,
    output logic [DATASIZE-1:0]  c_diff_c2g,
    output logic [COUNTSIZE-1:0] c_diff_count_c2g,
    output logic                 c_busy,
    output logic                 c_drop,
    output logic [COUNTSIZE-1:0] c_drops
);

    // The phase counter must cover the longer of the setup and hold windows.
    localparam int MAXC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ASSERT, S_RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ph_q, ph_d;
    logic [DATASIZE-1:0]    timer_q, timer_d;
    logic [COUNTSIZE-1:0]   evcnt_q, evcnt_d;
    logic                   pv_q, pv_d;
    logic [DATASIZE-1:0]    pdiff_q, pdiff_d;
    logic [COUNTSIZE-1:0]   pcnt_q, pcnt_d;
    logic                   det_q, det_d;
    logic [DATASIZE-1:0]    diff_q, diff_d;
    logic [COUNTSIZE-1:0]   dcnt_q, dcnt_d;
    logic                   drop_q, drop_d;
    logic [COUNTSIZE-1:0]   drops_q, drops_d;

    logic                   accept;
    logic                   load;
    logic [DATASIZE-1:0]    ld_diff;
    logic [COUNTSIZE-1:0]   ld_cnt;
    logic [COUNTSIZE-1:0]   cap_cnt;

    // Next-state logic: timer, event numbering, routing, and the transfer FSM.
    always_comb begin
        accept  = c_event & c_enable;
        cap_cnt = evcnt_q + COUNTSIZE'(1);

        timer_d = timer_q;
        if (c_enable) begin
            if (accept)
                timer_d = DATASIZE'(1);
            else if (timer_q != '1)
                timer_d = timer_q + DATASIZE'(1);
        end
        evcnt_d = accept ? cap_cnt : evcnt_q;

        state_d = state_q;
        ph_d    = ph_q;
        det_d   = det_q;
        diff_d  = diff_q;
        dcnt_d  = dcnt_q;
        pv_d    = pv_q;
        pdiff_d = pdiff_q;
        pcnt_d  = pcnt_q;
        drop_d  = 1'b0;
        drops_d = drops_q;
        load    = 1'b0;
        ld_diff = timer_q;
        ld_cnt  = cap_cnt;

        case (state_q)
            S_IDLE: begin
                // The older pending entry goes first. A coincident new event
                // takes the slot that has just been freed, so it is not dropped.
                if (pv_q) begin
                    load    = 1'b1;
                    ld_diff = pdiff_q;
                    ld_cnt  = pcnt_q;
                    pv_d    = accept;
                    if (accept) begin
                        pdiff_d = timer_q;
                        pcnt_d  = cap_cnt;
                    end
                end else if (accept) begin
                    load = 1'b1;
                end
            end
            S_SETUP: begin
                if (ph_q == CW'(SETUP_CYC - 1)) begin
                    state_d = S_ASSERT;
                    ph_d    = '0;
                    det_d   = 1'b1;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            S_ASSERT: begin
                if (ph_q == CW'(HOLD_CYC - 1)) begin
                    state_d = S_RELEASE;
                    ph_d    = '0;
                    det_d   = 1'b0;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            S_RELEASE: begin
                if (ph_q == CW'(HOLD_CYC - 1)) begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // While a transfer is in flight, a new event uses the single pending
        // slot if it is free. Otherwise the event is lost, but its number stays consumed.
        if (state_q != S_IDLE && accept) begin
            if (!pv_q) begin
                pv_d    = 1'b1;
                pdiff_d = timer_q;
                pcnt_d  = cap_cnt;
            end else begin
                drop_d  = 1'b1;
                drops_d = drops_q + COUNTSIZE'(1);
            end
        end

        // The data outputs change only here, so they are stable for the whole handshake.
        if (load) begin
            diff_d  = ld_diff;
            dcnt_d  = ld_cnt;
            state_d = S_SETUP;
            ph_d    = '0;
        end
    end

    // State register: every register clears asynchronously, which also discards any pending entry.
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            timer_q <= '0;
            evcnt_q <= '0;
            pv_q    <= 1'b0;
            pdiff_q <= '0;
            pcnt_q  <= '0;
            det_q   <= 1'b0;
            diff_q  <= '0;
            dcnt_q  <= '0;
            drop_q  <= 1'b0;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            timer_q <= timer_d;
            evcnt_q <= evcnt_d;
            pv_q    <= pv_d;
            pdiff_q <= pdiff_d;
            pcnt_q  <= pcnt_d;
            det_q   <= det_d;
            diff_q  <= diff_d;
            dcnt_q  <= dcnt_d;
            drop_q  <= drop_d;
            drops_q <= drops_d;
        end
    end

    assign c_detect_c2g     = det_q;
    assign c_diff_c2g       = diff_q;
    assign c_diff_count_c2g = dcnt_q;
    assign c_busy           = (state_q != S_IDLE);
    assign c_drop           = drop_q;
    assign c_drops          = drops_q;

endmodule

// File: tb/tb_cdc_c2g_tx.sv
// Bench for cdc_c2g_tx with default parameters.
// The expected {diff, count} of each transfer is queued when its event is
// driven. A monitor checks the queued value against the data when detect
// rises, and checks hold length and data stability when detect falls.
module tb_cdc_c2g_tx;

    logic        c_clk;
    logic        c_rst;
    logic        c_enable;
    logic        c_event;
    logic        c_detect_c2g;
    logic [15:0] c_diff_c2g;
    logic [31:0] c_diff_count_c2g;
    logic        c_busy;
    logic        c_drop;
    logic [31:0] c_drops;

    cdc_c2g_tx dut (
        .c_clk            (c_clk),
        .c_rst            (c_rst),
        .c_enable         (c_enable),
        .c_event          (c_event),
        .c_detect_c2g     (c_detect_c2g),
        .c_diff_c2g       (c_diff_c2g),
        .c_diff_count_c2g (c_diff_count_c2g),
        .c_busy           (c_busy),
        .c_drop           (c_drop),
        .c_drops          (c_drops)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [15:0] diff;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        int          gap;
        logic [15:0] diff;
        logic [31:0] cnt;
        logic        drop;
        logic [31:0] drops;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge c_clk);
        #1;
    endtask

    // Drive one event so that it is sampled at the next edge, then land just after that edge.
    task automatic pulse();
        c_event = 1'b1;
        @(posedge c_clk);
        #1;
        c_event = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic [31:0] c);
        exp_t e;
        e.diff = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    // Monitor: score each transfer at the detect rise, then check its hold length and stability at the fall.
    logic        det_prev = 1'b0;
    int          hi_cnt   = 0;
    logic [15:0] rise_diff;
    logic [31:0] rise_cnt;
    always @(negedge c_clk) begin
        if (c_rst) begin
            det_prev = 1'b0;
            hi_cnt   = 0;
        end else begin
            if (c_detect_c2g && !det_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got transfer diff=%0d count=%0d required none",
                             c_diff_c2g, c_diff_count_c2g);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_diff", 64'(c_diff_c2g), 64'(e.diff));
                    chk("sb_count", 64'(c_diff_count_c2g), 64'(e.cnt));
                end
                rise_diff = c_diff_c2g;
                rise_cnt  = c_diff_count_c2g;
                hi_cnt    = 1;
            end else if (c_detect_c2g) begin
                hi_cnt++;
            end else if (det_prev) begin
                chk("hold_len", 64'(hi_cnt), 64'd8);
                chk("hold_data", {16'd0, c_diff_c2g, c_diff_count_c2g}, {16'd0, rise_diff, rise_cnt});
            end
            det_prev = c_detect_c2g;
        end
    end

    vec_t tbl[9];

    initial begin
        // gap = idle edges before the event. Spacing gap+1 therefore gives diff=gap+1.
        tbl[0] = '{30, 16'd31, 32'd4,  1'b0, 32'd0};  // from IDLE: direct load
        tbl[1] = '{0,  16'd1,  32'd5,  1'b0, 32'd0};  // busy: into pending
        tbl[2] = '{0,  16'd1,  32'd6,  1'b1, 32'd1};  // pending full: dropped
        tbl[3] = '{40, 16'd41, 32'd7,  1'b0, 32'd1};  // after drop: number 6 was consumed
        tbl[4] = '{30, 16'd31, 32'd8,  1'b0, 32'd1};  // load at F
        tbl[5] = '{0,  16'd1,  32'd9,  1'b0, 32'd1};  // pending
        tbl[6] = '{17, 16'd18, 32'd10, 1'b0, 32'd1};  // F+19: pending loads, this takes the slot
        tbl[7] = '{0,  16'd1,  32'd11, 1'b1, 32'd2};  // slot full again: drop
        tbl[8] = '{0,  16'd1,  32'd12, 1'b1, 32'd3};  // drop

        c_rst    = 1'b1;
        c_enable = 1'b0;
        c_event  = 1'b0;
        #1;
        chk("rst_detect", 64'(c_detect_c2g), 64'd0);
        chk("rst_diff", 64'(c_diff_c2g), 64'd0);
        chk("rst_count", 64'(c_diff_count_c2g), 64'd0);
        chk("rst_busy", 64'(c_busy), 64'd0);
        chk("rst_drop", 64'(c_drop), 64'd0);
        chk("rst_drops", 64'(c_drops), 64'd0);
        idle(5);
        c_rst = 1'b0;
        idle(3);

        // Enable and event arrive together: the timer is still 0 and the number is 1.
        c_enable = 1'b1;
        push(16'd0, 32'd1);
        pulse();
        chk("first_count", 64'(c_diff_count_c2g), 64'd1);
        chk("first_diff", 64'(c_diff_c2g), 64'd0);

        // A second event 37 edges later gives diff 37. Check the exact detect window.
        idle(36);
        push(16'd37, 32'd2);
        pulse();
        chk("e2_busy", 64'(c_busy), 64'd1);
        chk("e2_diff", 64'(c_diff_c2g), 64'd37);
        chk("e2_count", 64'(c_diff_count_c2g), 64'd2);
        chk("e2_det_e0", 64'(c_detect_c2g), 64'd0);
        idle(1);
        chk("e2_det_e1", 64'(c_detect_c2g), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            idle(1);
            chk("e2_det_high", 64'(c_detect_c2g), 64'd1);
        end
        idle(1);
        chk("e2_det_fall", 64'(c_detect_c2g), 64'd0);
        idle(7);
        chk("e2_busy_e17", 64'(c_busy), 64'd1);
        idle(1);
        chk("e2_busy_e18", 64'(c_busy), 64'd0);
        chk("e2_hold_diff", 64'(c_diff_c2g), 64'd37);
        chk("e2_hold_count", 64'(c_diff_count_c2g), 64'd2);

        // Saturation: the events are 70001 edges apart.
        idle(70000);
        push(16'hFFFF, 32'd3);
        pulse();
        chk("sat_diff", 64'(c_diff_c2g), 64'd65535);

        // Table-driven bursts, drops, and the simultaneous pending-load case.
        for (int i = 0; i < 9; i++) begin
            idle(tbl[i].gap);
            if (!tbl[i].drop) push(tbl[i].diff, tbl[i].cnt);
            pulse();
            chk($sformatf("tbl%0d_drop", i), 64'(c_drop), 64'(tbl[i].drop));
            chk($sformatf("tbl%0d_drops", i), 64'(c_drops), 64'(tbl[i].drops));
        end
        idle(1);
        chk("drop_one_cycle", 64'(c_drop), 64'd0);
        idle(59);

        // Disabled: the event pulses are ignored and the timer stays frozen at 61.
        c_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(9);
            pulse();
            chk("dis_busy", 64'(c_busy), 64'd0);
            chk("dis_drop", 64'(c_drop), 64'd0);
        end
        chk("dis_drops", 64'(c_drops), 64'd3);
        c_enable = 1'b1;
        push(16'd61, 32'd13);
        pulse();
        chk("reen_count", 64'(c_diff_count_c2g), 64'd13);
        chk("reen_diff", 64'(c_diff_c2g), 64'd61);
        idle(25);

        // Reset during ASSERT with the pending slot full. The pending event is never pushed because it must be lost.
        push(16'd26, 32'd14);
        pulse();
        pulse();
        idle(3);
        chk("mid_det", 64'(c_detect_c2g), 64'd1);
        #2;
        c_rst = 1'b1;
        #1;
        chk("arst_det", 64'(c_detect_c2g), 64'd0);
        chk("arst_busy", 64'(c_busy), 64'd0);
        chk("arst_diff", 64'(c_diff_c2g), 64'd0);
        chk("arst_count", 64'(c_diff_count_c2g), 64'd0);
        chk("arst_drops", 64'(c_drops), 64'd0);
        sb.delete();
        repeat (5) @(posedge c_clk);
        #1;
        c_rst = 1'b0;
        idle(30);
        chk("post_rst_busy", 64'(c_busy), 64'd0);
        chk("post_rst_det", 64'(c_detect_c2g), 64'd0);
        push(16'd30, 32'd1);
        pulse();
        chk("post_rst_count", 64'(c_diff_count_c2g), 64'd1);
        chk("post_rst_diff", 64'(c_diff_c2g), 64'd30);
        idle(25);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("final_drops", 64'(c_drops), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
